// File: rtl/uart_loopback_fifo_if.sv
// uart_loopback_fifo_if: serial lines, flow control and debug status of the UART echo engine
interface uart_loopback_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          uart_rx;
  logic                          uart_tx;
  logic                          tx_hold;
  logic [DATA_BITS-1:0]          rx_data;
  logic                          rx_valid;
  logic                          frame_err;
  logic                          parity_err;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          tx_busy;
  modport slave (
    input  uart_rx, tx_hold,
    output uart_tx, rx_data, rx_valid, frame_err, parity_err, overflow, fifo_level, tx_busy
  );
  modport master (
    output uart_rx, tx_hold,
    input  uart_tx, rx_data, rx_valid, frame_err, parity_err, overflow, fifo_level, tx_busy
  );
endinterface

// File: rtl/uart_loopback_fifo.sv
// uart_loopback_fifo: UART RX -> FIFO -> UART TX echo; define UART_PARITY_EN to add a parity bit on both sides
module uart_loopback_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input logic clk,
  input logic rst,
  uart_loopback_fifo_if.slave bus
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(2 * STOP_BITS * CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [CW-1:0] HALF     = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CPB - 1);
  localparam logic [3:0]    LAST     = 4'(DATA_BITS - 1);
  localparam logic [LW-1:0] DEPTH    = LW'(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_st_t;
  localparam rx_st_t RX_NEXT = RX_PAR;
  localparam tx_st_t TX_NEXT = TX_PAR;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_st_t;
  localparam rx_st_t RX_NEXT = RX_STOP;
  localparam tx_st_t TX_NEXT = TX_STOP;
`endif
  logic                 rx_s1_q, rx_s2_q, rx_s3_q, rxs, rx_fall;
  rx_st_t               rx_st_q, rx_st_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q;
  logic                 rx_pbad_q, rx_pbad_d, rx_tick, rx_stop, rx_good, rx_ferr, rx_perr;
  logic                 rx_valid_q, frame_err_q, parity_err_q;
  tx_st_t               tx_st_q, tx_st_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif
  logic                 tx_tick, tx_restart, uart_tx, tx_busy;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [LW-1:0]        lvl_q, lvl_d;
  logic                 ovf_q, push, pop;
  assign rxs     = rx_s2_q;
  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = rx_cnt_q == (rx_st_q == RX_START ? HALF : FULL);
  assign tx_tick = tx_cnt_q == FULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
      rx_st_q      <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_pbad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      tx_st_q      <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '0;
`ifdef UART_PARITY_EN
      tx_par_q     <= 1'b0;
`endif
      wp_q         <= '0;
      rp_q         <= '0;
      lvl_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= {bus.uart_rx, rx_s1_q, rx_s2_q};
      rx_st_q      <= rx_st_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      rx_pbad_q    <= rx_pbad_d;
      rx_data_q    <= rx_good ? rx_sh_q : rx_data_q;
      rx_valid_q   <= rx_good;
      frame_err_q  <= rx_ferr;
      parity_err_q <= rx_perr;
      tx_st_q      <= tx_st_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
`ifdef UART_PARITY_EN
      tx_par_q     <= tx_par_d;
`endif
      wp_q         <= wp_q + AW'(push);
      rp_q         <= rp_q + AW'(pop);
      lvl_q        <= lvl_d;
      ovf_q        <= ovf_q | (rx_good & ~push);
    end
  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      RX_IDLE:  if (rx_fall) rx_st_d = RX_START;
      RX_START: if (rx_tick) rx_st_d = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_q == LAST) rx_st_d = RX_NEXT;
`ifdef UART_PARITY_EN
      RX_PAR:   if (rx_tick) rx_st_d = RX_STOP;
`endif
      RX_STOP:  if (rx_tick) rx_st_d = RX_IDLE;
      default:  rx_st_d = RX_IDLE;
    endcase
  end
  always_comb begin
    rx_cnt_d = (rx_st_q == RX_IDLE || rx_tick) ? '0 : rx_cnt_q + CW'(1);
    rx_bit_d = rx_st_q != RX_DATA ? '0 : rx_bit_q + 4'(rx_tick);
    rx_sh_d  = (rx_st_q == RX_DATA && rx_tick) ? {rxs, rx_sh_q[DATA_BITS-1:1]} : rx_sh_q;
`ifdef UART_PARITY_EN
    rx_pbad_d = rx_st_q == RX_IDLE ? 1'b0 :
                (rx_st_q == RX_PAR && rx_tick) ? ((^{rxs, rx_sh_q}) != PARITY_ODD[0]) : rx_pbad_q;
`else
    rx_pbad_d = 1'b0;
`endif
    rx_stop = rx_st_q == RX_STOP && rx_tick;
    rx_good = rx_stop && rxs && !rx_pbad_q;
    rx_ferr = rx_stop && !rxs;
    rx_perr = rx_stop && rx_pbad_q;
  end
  always_comb begin
    tx_st_d = tx_st_q;
    case (tx_st_q)
      TX_IDLE:  if (lvl_q != '0 && !bus.tx_hold) tx_st_d = TX_LOAD;
      TX_LOAD:  tx_st_d = TX_START;
      TX_START: if (tx_tick) tx_st_d = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit_q == LAST) tx_st_d = TX_NEXT;
`ifdef UART_PARITY_EN
      TX_PAR:   if (tx_tick) tx_st_d = TX_STOP;
`endif
      TX_STOP:  if (tx_cnt_q == STOP_END) tx_st_d = TX_IDLE;
      default:  tx_st_d = TX_IDLE;
    endcase
  end
  always_comb begin
    pop        = tx_st_q == TX_LOAD;
    tx_restart = tx_st_d != tx_st_q || (tx_st_q == TX_DATA && tx_tick) || tx_st_q == TX_IDLE;
    tx_cnt_d   = tx_restart ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_st_q != TX_DATA ? '0 : tx_bit_q + 4'(tx_tick);
    tx_sh_d    = pop ? mem[rp_q] : (tx_st_q == TX_DATA && tx_tick) ? tx_sh_q >> 1 : tx_sh_q;
`ifdef UART_PARITY_EN
    tx_par_d   = pop ? ((^mem[rp_q]) ^ PARITY_ODD[0]) : tx_par_q;
    uart_tx    = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] :
                 tx_st_q == TX_PAR ? tx_par_q : 1'b1;
`else
    uart_tx    = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] : 1'b1;
`endif
    tx_busy    = !(tx_st_q inside {TX_IDLE, TX_LOAD});
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push       = rx_good && (lvl_q != DEPTH || pop);
    lvl_d      = lvl_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wp_q] <= rx_sh_q;
  assign bus.uart_tx    = uart_tx;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_level = lvl_q;
  assign bus.tx_busy    = tx_busy;
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// tb_uart_loopback_fifo: table vectors, corner sequences and random frames checked against a queue model
module tb_uart_loopback_fifo;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0, fails = 0;
  int   rv_cnt = 0, fe_cnt = 0, pe_cnt = 0, max_lvl = 0, rv_cyc = 0;
  int   tx_falls = 0, tx_bad = 0, fall_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] tx_b;
  bit         tx_abort;

  uart_loopback_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) u_if ();
  uart_loopback_fifo #(
    .CLK_FREQ(50000000), .BAUD(3125000), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)
  ) dut (.clk(clk), .rst(rst), .bus(u_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial forever begin
    @(posedge clk); #1;
    if (u_if.rx_valid) begin rv_cnt++; rx_q.push_back(u_if.rx_data); rv_cyc = cyc; end
    if (u_if.frame_err) fe_cnt++;
    if (u_if.parity_err) pe_cnt++;
    if (int'(u_if.fifo_level) > max_lvl) max_lvl = int'(u_if.fifo_level);
  end

  // decodes each TX frame; any sample disagreeing with its 16-clock bit window is a width error
  initial forever begin
    @(posedge clk); #1;
    if (!rst && u_if.uart_tx === 1'b0) begin
      tx_falls++; fall_cyc = cyc; tx_b = '0; tx_abort = 0;
      for (int s = 0; s < 160 && !tx_abort; s++) begin
        if (s > 0) begin @(posedge clk); #1; end
        if (rst) tx_abort = 1;
        else if (s < 16) begin if (u_if.uart_tx !== 1'b0) tx_bad++; end
        else if (s < 144) begin
          if (s % 16 == 0) tx_b[s/16-1] = u_if.uart_tx;
          else if (u_if.uart_tx !== tx_b[s/16-1]) tx_bad++;
        end else if (u_if.uart_tx !== 1'b1) tx_bad++;
      end
      if (!tx_abort) tx_q.push_back(tx_b);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    u_if.uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop_ok, CPB);
    if (gap > 0) line(1'b1, gap);
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (!(u_if.tx_busy == 1'b0 && u_if.fifo_level == '0) && k < max) begin
      @(negedge clk); k++;
    end
    repeat (4) @(negedge clk);
    chk("idle_timeout", int'(k < max), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    bit         exp_valid;
    bit         exp_ferr;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] model_fifo[$];
    int rv0, fe0, tx0, rx0, f0, k, nbad;
    bit model_ovf;
    vecs[0] = '{8'hAA, 1'b1, 20, 1'b1, 1'b0};
    vecs[1] = '{8'h81, 1'b0, 20, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 20, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 20, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 32, 1'b0, 1'b1};
    vecs[5] = '{8'hC3, 1'b1, 20, 1'b1, 1'b0};
    u_if.uart_rx = 1'b1; u_if.tx_hold = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", int'(u_if.uart_tx), 1);
    chk("rst_rx_data", int'(u_if.rx_data), 0);
    chk("rst_rx_valid", int'(u_if.rx_valid), 0);
    chk("rst_frame_err", int'(u_if.frame_err), 0);
    chk("rst_parity_err", int'(u_if.parity_err), 0);
    chk("rst_overflow", int'(u_if.overflow), 0);
    chk("rst_fifo_level", int'(u_if.fifo_level), 0);
    chk("rst_tx_busy", int'(u_if.tx_busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      rv0 = rv_cnt; fe0 = fe_cnt; tx0 = tx_q.size(); f0 = tx_falls;
      send_byte(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      wait_idle(400);
      chk("vec_rx_valid", rv_cnt - rv0, int'(vecs[i].exp_valid));
      chk("vec_frame_err", fe_cnt - fe0, int'(vecs[i].exp_ferr));
      chk("vec_tx_frames", tx_q.size() - tx0, int'(vecs[i].exp_valid));
      chk("vec_fifo_level", int'(u_if.fifo_level), 0);
      if (vecs[i].exp_valid) begin
        chk("vec_rx_data", int'(u_if.rx_data), int'(vecs[i].data));
        chk("vec_tx_data", int'(tx_q[tx_q.size()-1]), int'(vecs[i].data));
        chk("vec_latency", fall_cyc - rv_cyc, 2);
      end else chk("vec_tx_quiet", tx_falls - f0, 0);
    end
    chk("tx_bit_width", tx_bad, 0);

    exp_q = '{8'h55, 8'h0F, 8'hF0};
    rv0 = rv_cnt; rx0 = rx_q.size(); tx0 = tx_q.size();
    foreach (exp_q[i]) send_byte(exp_q[i], 1'b1, 0);
    line(1'b1, 20);
    wait_idle(800);
    chk("b2b_rx_count", rv_cnt - rv0, 3);
    chk("b2b_tx_count", tx_q.size() - tx0, 3);
    foreach (exp_q[i]) begin
      chk("b2b_rx_data", int'(rx_q[rx0+i]), int'(exp_q[i]));
      chk("b2b_tx_data", int'(tx_q[tx0+i]), int'(exp_q[i]));
    end
    chk("b2b_max_level", int'(max_lvl <= 1), 1);

    rv0 = rv_cnt; fe0 = fe_cnt;
    line(1'b0, 4);
    line(1'b1, 40);
    chk("glitch_rx_valid", rv_cnt - rv0, 0);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    send_byte(8'h3C, 1'b1, 20);
    wait_idle(400);
    chk("glitch_next_valid", rv_cnt - rv0, 1);
    chk("glitch_next_data", int'(u_if.rx_data), 8'h3C);

    u_if.tx_hold = 1'b1;
    tx0 = tx_q.size(); model_fifo.delete(); model_ovf = 0;
    for (int i = 0; i <= 16; i++) begin
      send_byte(8'(i), 1'b1, 0);
      if (model_fifo.size() < 16) model_fifo.push_back(8'(i)); else model_ovf = 1;
    end
    line(1'b1, 20);
    chk("hold_level", int'(u_if.fifo_level), model_fifo.size());
    chk("hold_overflow", int'(u_if.overflow), int'(model_ovf));
    chk("hold_rx_data", int'(u_if.rx_data), 8'h10);
    chk("hold_no_tx", tx_q.size() - tx0, 0);
    u_if.tx_hold = 1'b0;
    wait_idle(3500);
    chk("drain_count", tx_q.size() - tx0, model_fifo.size());
    foreach (model_fifo[i]) chk("drain_data", int'(tx_q[tx0+i]), int'(model_fifo[i]));
    chk("drain_level", int'(u_if.fifo_level), 0);
    chk("drain_overflow", int'(u_if.overflow), 1);

    exp_q.delete(); nbad = 0;
    rx0 = rx_q.size(); tx0 = tx_q.size(); fe0 = fe_cnt;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      bit ok = $urandom_range(0, 4) != 0;
      int gap = ok ? ($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40)) : 16 + $urandom_range(0, 20);
      send_byte(b, ok, gap);
      if (ok) exp_q.push_back(b); else nbad++;
    end
    line(1'b1, 20);
    wait_idle(1500);
    chk("rand_rx_count", rx_q.size() - rx0, exp_q.size());
    chk("rand_tx_count", tx_q.size() - tx0, exp_q.size());
    chk("rand_frame_err", fe_cnt - fe0, nbad);
    k = 0;
    foreach (exp_q[i]) k += int'(rx_q[rx0+i] != exp_q[i]) + int'(tx_q[tx0+i] != exp_q[i]);
    chk("rand_data_errors", k, 0);
    chk("tx_bit_width_all", tx_bad, 0);
    chk("parity_err_never", pe_cnt, 0);

    u_if.tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b1, 0);
    line(1'b1, 20);
    chk("pre_rst_level", int'(u_if.fifo_level), 4);
    f0 = tx_falls;
    u_if.tx_hold = 1'b0;
    k = 0;
    while (tx_falls == f0 && k < 50) begin @(negedge clk); k++; end
    chk("pre_rst_tx_start", int'(k < 50), 1);
    repeat (40) @(negedge clk);
    chk("pre_rst_queued", int'(u_if.fifo_level), 3);
    chk("pre_rst_busy", int'(u_if.tx_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_uart_tx", int'(u_if.uart_tx), 1);
    chk("rst_mid_tx_busy", int'(u_if.tx_busy), 0);
    chk("rst_mid_level", int'(u_if.fifo_level), 0);
    chk("rst_mid_overflow", int'(u_if.overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = tx_falls;
    repeat (400) @(negedge clk);
    chk("post_rst_no_tx", tx_falls - f0, 0);
    chk("post_rst_level", int'(u_if.fifo_level), 0);
    chk("post_rst_uart_tx", int'(u_if.uart_tx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
